// File: rtl/mem_arbiter.sv
// mem_arbiter: byte-serial controller that arbitrates NUM_PORTS requesters
// onto one 8-bit external memory bus. Each access moves 1, 2 or 4 bytes,
// little-endian, one byte per cycle. Arbitration is round-robin or fixed
// priority. IO stores are held back while the IO buffer is full.
//
// Ports:
//   clk_in, rst_in (async, active-low), rdy_in (global freeze), clear_in
//   mem_din / mem_dout / mem_a / mem_wr   external memory bus
//   io_buffer_full                        IO back-pressure
//   req_valid/write/size/addr/wdata       per-port packed request fields
//   req_accept, resp_valid                one-hot one-cycle pulses
//   resp_rdata                            zero-extended load data
//   busy                                  FSM is not in IDLE
module mem_arbiter #(
  parameter int                NUM_PORTS = 3,
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] IO_BASE   = ADDR_W'(32'h30000),
  parameter int                RR_EN     = 1
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        rdy_in,
  input  logic                        clear_in,
  input  logic [7:0]                  mem_din,
  output logic [7:0]                  mem_dout,
  output logic [ADDR_W-1:0]           mem_a,
  output logic                        mem_wr,
  input  logic                        io_buffer_full,
  input  logic [NUM_PORTS-1:0]        req_valid,
  input  logic [NUM_PORTS-1:0]        req_write,
  input  logic [2*NUM_PORTS-1:0]      req_size,
  input  logic [ADDR_W*NUM_PORTS-1:0] req_addr,
  input  logic [32*NUM_PORTS-1:0]     req_wdata,
  output logic [NUM_PORTS-1:0]        req_accept,
  output logic [NUM_PORTS-1:0]        resp_valid,
  output logic [31:0]                 resp_rdata,
  output logic                        busy
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [1:0] {IDLE, XFER, LAST} state_t;

  state_t       state;
  logic [PW-1:0] rr_ptr;     // last granted port
  logic [PW-1:0] owner;      // port of the access in flight
  logic          is_write;
  logic [1:0]    idx;        // index of the byte currently on the bus
  logic [1:0]    last_idx;   // B-1
  logic [23:0]   wshift;     // write bytes not yet driven

  logic [NUM_PORTS-1:0] eligible;
  logic                 grant_found;
  logic [PW-1:0]        grant_idx;
  logic [PW-1:0]        cand;
  logic [ADDR_W-1:0]    sel_addr;
  logic [1:0]           sel_size;
  logic                 sel_write;
  logic [31:0]          sel_wdata;
  logic                 store_en;
  logic [1:0]           store_sel;

  // NOTE: every signal written in always_comb gets a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    eligible = '0;
    for (int p = 0; p < NUM_PORTS; p++)
      eligible[p] = req_valid[p] &&
                    !(io_buffer_full && (req_addr[p*ADDR_W +: ADDR_W] >= IO_BASE));
  end

  // Round-robin scans from the port after the last grant; fixed priority
  // scans from port 0. The first eligible port in scan order wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (RR_EN != 0) cand = PW'((int'(rr_ptr) + 1 + k) % NUM_PORTS);
      else            cand = PW'(k);
      if (!grant_found && eligible[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    sel_addr  = '0;
    sel_size  = '0;
    sel_write = 1'b0;
    sel_wdata = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (grant_idx == PW'(p)) begin
        sel_addr  = req_addr[p*ADDR_W +: ADDR_W];
        sel_size  = req_size[2*p +: 2];
        sel_write = req_write[p];
        sel_wdata = req_wdata[32*p +: 32];
      end
    end
  end

  // The external memory answers one cycle after the address, so the byte
  // sampled while byte i is on the bus is byte i-1; LAST picks up the final one.
  always_comb begin
    store_en  = 1'b0;
    store_sel = '0;
    if (state == XFER && !is_write && !clear_in && idx != 2'd0) begin
      store_en  = 1'b1;
      store_sel = idx - 2'd1;
    end else if (state == LAST && !clear_in) begin
      store_en  = 1'b1;
      store_sel = last_idx;
    end
  end

  assign busy = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees pre-edge values regardless of statement order.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state      <= IDLE;
      rr_ptr     <= PW'(NUM_PORTS - 1);
      owner      <= '0;
      is_write   <= 1'b0;
      idx        <= '0;
      last_idx   <= '0;
      wshift     <= '0;
      mem_a      <= '0;
      mem_dout   <= '0;
      mem_wr     <= 1'b0;
      req_accept <= '0;
      resp_valid <= '0;
      resp_rdata <= '0;
    end else if (rdy_in) begin
      req_accept <= '0;
      resp_valid <= '0;
      for (int b = 0; b < 4; b++)
        if (store_en && store_sel == 2'(b)) resp_rdata[8*b +: 8] <= mem_din;

      unique case (state)
        IDLE: begin
          mem_wr <= 1'b0;
          if (grant_found && !clear_in) begin
            state      <= XFER;
            rr_ptr     <= grant_idx;
            owner      <= grant_idx;
            is_write   <= sel_write;
            idx        <= '0;
            last_idx   <= (sel_size == 2'b00) ? 2'd0 :
                          (sel_size == 2'b01) ? 2'd1 : 2'd3;
            mem_a      <= sel_addr;
            mem_wr     <= sel_write;
            mem_dout   <= sel_write ? sel_wdata[7:0] : 8'h00;
            wshift     <= sel_write ? sel_wdata[31:8] : 24'h0;
            resp_rdata <= '0;
            req_accept <= NUM_PORTS'(1) << grant_idx;
          end
        end

        XFER: begin
          if (clear_in && !is_write) begin
            // Reads abort; writes always run to completion.
            state  <= IDLE;
            mem_wr <= 1'b0;
          end else if (idx == last_idx) begin
            if (is_write) begin
              state      <= IDLE;
              mem_wr     <= 1'b0;
              resp_valid <= NUM_PORTS'(1) << owner;
            end else begin
              state <= LAST;
            end
          end else begin
            idx      <= idx + 2'd1;
            mem_a    <= mem_a + ADDR_W'(1);
            mem_dout <= wshift[7:0];
            wshift   <= wshift >> 8;
          end
        end

        LAST: begin
          state  <= IDLE;
          mem_wr <= 1'b0;
          if (!clear_in) resp_valid <= NUM_PORTS'(1) << owner;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter: word read, half write, round-robin vs
// fixed priority, IO gating, clear, stall and asynchronous reset. A second
// instance with fixed priority shares the request inputs.
module tb_mem_arbiter;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, clear_in, io_buffer_full;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout, fp_dout;
  logic [31:0] mem_a, fp_a;
  logic        mem_wr, fp_wr;
  logic [2:0]  req_valid, req_write;
  logic [5:0]  req_size;
  logic [95:0] req_addr, req_wdata;
  logic [2:0]  req_accept, resp_valid, fp_accept, fp_resp;
  logic [31:0] resp_rdata, fp_rdata;
  logic        busy, fp_busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] mem [0:1023];

  always #5 clk_in = ~clk_in;

  mem_arbiter dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_in(clear_in),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full), .req_valid(req_valid), .req_write(req_write),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_accept(req_accept), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .busy(busy)
  );

  mem_arbiter #(.RR_EN(0)) dut_fp (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_in(clear_in),
    .mem_din(mem_din), .mem_dout(fp_dout), .mem_a(fp_a), .mem_wr(fp_wr),
    .io_buffer_full(io_buffer_full), .req_valid(req_valid), .req_write(req_write),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_accept(fp_accept), .resp_valid(fp_resp), .resp_rdata(fp_rdata),
    .busy(fp_busy)
  );

  // Synchronous byte memory: read data appears one cycle after the address.
  always @(posedge clk_in) begin
    if (rdy_in) begin
      mem_din <= mem[mem_a[9:0]];
      if (mem_wr) mem[mem_a[9:0]] <= mem_dout;
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic set_req(input int p, input logic wr, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] d);
    req_valid[p]         = 1'b1;
    req_write[p]         = wr;
    req_size[2*p +: 2]   = sz;
    req_addr[32*p +: 32] = a;
    req_wdata[32*p +: 32] = d;
  endtask

  task automatic do_reset();
    rst_in = 1'b0;
    #2;
    rst_in = 1'b1;
    tick();
  endtask

  function automatic int onehot_idx(input logic [2:0] v);
    case (v)
      3'b001:  return 0;
      3'b010:  return 1;
      3'b100:  return 2;
      default: return -1;
    endcase
  endfunction

  task automatic test_reset();
    tick();
    n_tests++;
    if ({mem_a, mem_dout, mem_wr, req_accept, resp_valid, resp_rdata, busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got a=%h d=%h wr=%b acc=%b rv=%b rd=%h busy=%b want all 0",
               mem_a, mem_dout, mem_wr, req_accept, resp_valid, resp_rdata, busy);
    end
    rst_in = 1'b1;
    tick();
    n_tests++;
    if ({busy, req_accept} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_idle: got busy=%b acc=%b want 0/000", busy, req_accept);
    end
  endtask

  task automatic test_word_read();
    set_req(1, 1'b0, 2'b10, 32'h100, 32'h0);
    tick();  // edge 0
    n_tests++;
    if ({req_accept, mem_a, mem_wr, busy} !== {3'b010, 32'h100, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL rd_capture: got acc=%b a=%h wr=%b busy=%b want 010/100/0/1",
               req_accept, mem_a, mem_wr, busy);
    end
    req_valid = '0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      n_tests++;
      if ({mem_a, resp_valid, req_accept} !== {32'h100 + 32'(k), 3'b000, 3'b000}) begin
        n_fail++;
        $display("FAIL rd_addr%0d: got a=%h rv=%b acc=%b want %h/000/000",
                 k, mem_a, resp_valid, req_accept, 32'h100 + 32'(k));
      end
    end
    tick();  // edge 4
    n_tests++;
    if (resp_valid !== 3'b000) begin
      n_fail++;
      $display("FAIL rd_early: got rv=%b want 000", resp_valid);
    end
    tick();  // edge 5 = B+1
    n_tests++;
    if ({resp_valid, resp_rdata} !== {3'b010, 32'h44332211}) begin
      n_fail++;
      $display("FAIL rd_resp: got rv=%b data=%h want 010/44332211", resp_valid, resp_rdata);
    end
    tick();
    n_tests++;
    if ({resp_valid, busy} !== 4'b0) begin
      n_fail++;
      $display("FAIL rd_done: got rv=%b busy=%b want 000/0", resp_valid, busy);
    end
  endtask

  task automatic test_half_write();
    set_req(0, 1'b1, 2'b01, 32'h200, 32'hAABBCCDD);
    tick();  // edge 0
    n_tests++;
    if ({req_accept, mem_wr, mem_a, mem_dout} !== {3'b001, 1'b1, 32'h200, 8'hDD}) begin
      n_fail++;
      $display("FAIL wr_byte0: got acc=%b wr=%b a=%h d=%h want 001/1/200/dd",
               req_accept, mem_wr, mem_a, mem_dout);
    end
    req_valid = '0;
    tick();  // edge 1
    n_tests++;
    if ({mem_wr, mem_a, mem_dout, resp_valid} !== {1'b1, 32'h201, 8'hCC, 3'b000}) begin
      n_fail++;
      $display("FAIL wr_byte1: got wr=%b a=%h d=%h rv=%b want 1/201/cc/000",
               mem_wr, mem_a, mem_dout, resp_valid);
    end
    tick();  // edge 2 = B
    n_tests++;
    if ({mem_wr, resp_valid, busy} !== {1'b0, 3'b001, 1'b0}) begin
      n_fail++;
      $display("FAIL wr_resp: got wr=%b rv=%b busy=%b want 0/001/0", mem_wr, resp_valid, busy);
    end
    n_tests++;
    if ({mem[10'h200], mem[10'h201]} !== 16'hDDCC) begin
      n_fail++;
      $display("FAIL wr_mem: got %h%h want ddcc", mem[10'h200], mem[10'h201]);
    end
    tick();
  endtask

  task automatic test_round_robin();
    int g[4];
    int gi, fp_cnt, r;
    int exp_g[4] = '{0, 1, 2, 0};
    logic [7:0] rd_exp[3] = '{8'h5A, 8'h6B, 8'h7C};
    do_reset();
    gi = 0;
    fp_cnt = 0;
    for (int p = 0; p < 3; p++) set_req(p, 1'b0, 2'b00, 32'h10 + 32'(p), 32'h0);
    for (int c = 0; c < 40 && gi < 4; c++) begin
      tick();
      if (req_accept != 3'b000) begin
        g[gi] = onehot_idx(req_accept);
        gi++;
      end
      if (resp_valid != 3'b000) begin
        r = onehot_idx(resp_valid);
        n_tests++;
        if (r < 0 || resp_rdata !== {24'h0, rd_exp[r]}) begin
          n_fail++;
          $display("FAIL rr_data: got rv=%b data=%h", resp_valid, resp_rdata);
        end
      end
      if (fp_accept != 3'b000) begin
        fp_cnt++;
        n_tests++;
        if (fp_accept !== 3'b001) begin
          n_fail++;
          $display("FAIL fp_grant: got %b want 001", fp_accept);
        end
      end
    end
    n_tests++;
    if (gi != 4) begin
      n_fail++;
      $display("FAIL rr_timeout: got %0d grants want 4", gi);
    end
    for (int i = 0; i < gi; i++) begin
      n_tests++;
      if (g[i] != exp_g[i]) begin
        n_fail++;
        $display("FAIL rr_order%0d: got port %0d want %0d", i, g[i], exp_g[i]);
      end
    end
    n_tests++;
    if (fp_cnt != 4) begin
      n_fail++;
      $display("FAIL fp_count: got %0d want 4", fp_cnt);
    end
    req_valid = '0;
    repeat (4) tick();
  endtask

  task automatic test_io_gating();
    logic [2:0] seen;
    do_reset();
    io_buffer_full = 1'b1;
    set_req(0, 1'b1, 2'b00, 32'h30000, 32'h55);
    set_req(1, 1'b0, 2'b00, 32'h10, 32'h0);
    tick();
    n_tests++;
    if (req_accept !== 3'b010) begin
      n_fail++;
      $display("FAIL io_first: got acc=%b want 010", req_accept);
    end
    req_valid[1] = 1'b0;
    seen = '0;
    repeat (5) begin
      tick();
      seen |= req_accept;
    end
    n_tests++;
    if (seen !== 3'b000) begin
      n_fail++;
      $display("FAIL io_blocked: got acc=%b want 000", seen);
    end
    io_buffer_full = 1'b0;
    tick();
    n_tests++;
    if ({req_accept, mem_a, mem_wr, mem_dout} !== {3'b001, 32'h30000, 1'b1, 8'h55}) begin
      n_fail++;
      $display("FAIL io_grant: got acc=%b a=%h wr=%b d=%h want 001/30000/1/55",
               req_accept, mem_a, mem_wr, mem_dout);
    end
    req_valid = '0;
    tick();
    n_tests++;
    if ({resp_valid, mem_wr} !== 4'b0010) begin
      n_fail++;
      $display("FAIL io_resp: got rv=%b wr=%b want 001/0", resp_valid, mem_wr);
    end
    tick();
  endtask

  task automatic test_clear();
    logic [2:0] seen;
    // Clear in IDLE blocks acceptance for that cycle only.
    clear_in = 1'b1;
    set_req(2, 1'b0, 2'b10, 32'h100, 32'h0);
    tick();
    n_tests++;
    if ({req_accept, busy} !== 4'b0) begin
      n_fail++;
      $display("FAIL clr_idle: got acc=%b busy=%b want 000/0", req_accept, busy);
    end
    clear_in = 1'b0;
    tick();  // edge 0
    n_tests++;
    if (req_accept !== 3'b100) begin
      n_fail++;
      $display("FAIL clr_accept: got acc=%b want 100", req_accept);
    end
    req_valid = '0;
    tick();  // byte 1 now on the bus
    clear_in = 1'b1;
    tick();
    clear_in = 1'b0;
    n_tests++;
    if ({busy, mem_wr, resp_valid} !== 5'b0) begin
      n_fail++;
      $display("FAIL clr_rd_abort: got busy=%b wr=%b rv=%b want 0/0/000", busy, mem_wr, resp_valid);
    end
    seen = '0;
    repeat (5) begin
      tick();
      seen |= resp_valid;
    end
    n_tests++;
    if (seen !== 3'b000) begin
      n_fail++;
      $display("FAIL clr_rd_noresp: got rv=%b want 000", seen);
    end
    // Clear during a write is ignored.
    set_req(0, 1'b1, 2'b10, 32'h300, 32'hDEADBEEF);
    tick();  // edge 0
    req_valid = '0;
    tick();
    clear_in = 1'b1;
    tick();
    tick();
    clear_in = 1'b0;
    n_tests++;
    if ({mem_wr, mem_a, mem_dout, resp_valid} !== {1'b1, 32'h303, 8'hDE, 3'b000}) begin
      n_fail++;
      $display("FAIL clr_wr_busy: got wr=%b a=%h d=%h rv=%b want 1/303/de/000",
               mem_wr, mem_a, mem_dout, resp_valid);
    end
    tick();  // edge 4 = B
    n_tests++;
    if ({resp_valid, mem_wr} !== 4'b0010) begin
      n_fail++;
      $display("FAIL clr_wr_resp: got rv=%b wr=%b want 001/0", resp_valid, mem_wr);
    end
    n_tests++;
    if ({mem[10'h303], mem[10'h302], mem[10'h301], mem[10'h300]} !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL clr_wr_mem: got %h%h%h%h want deadbeef",
               mem[10'h303], mem[10'h302], mem[10'h301], mem[10'h300]);
    end
    tick();
  endtask

  task automatic test_stall();
    set_req(1, 1'b0, 2'b10, 32'h100, 32'h0);
    tick();  // edge 0
    req_valid = '0;
    tick();
    tick();  // byte 2 on the bus
    rdy_in = 1'b0;
    repeat (3) tick();
    n_tests++;
    if ({mem_a, busy, resp_valid} !== {32'h102, 1'b1, 3'b000}) begin
      n_fail++;
      $display("FAIL stall_hold: got a=%h busy=%b rv=%b want 102/1/000", mem_a, busy, resp_valid);
    end
    rdy_in = 1'b1;
    tick();
    tick();
    n_tests++;
    if (resp_valid !== 3'b000) begin
      n_fail++;
      $display("FAIL stall_early: got rv=%b want 000", resp_valid);
    end
    tick();
    n_tests++;
    if ({resp_valid, resp_rdata} !== {3'b010, 32'h44332211}) begin
      n_fail++;
      $display("FAIL stall_resp: got rv=%b data=%h want 010/44332211", resp_valid, resp_rdata);
    end
    tick();
  endtask

  task automatic test_async_reset();
    set_req(1, 1'b0, 2'b10, 32'h100, 32'h0);
    tick();
    req_valid = '0;
    tick();
    tick();
    #2;
    rst_in = 1'b0;
    #1;
    n_tests++;
    if ({mem_a, mem_dout, mem_wr, req_accept, resp_valid, resp_rdata, busy} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: got a=%h d=%h wr=%b acc=%b rv=%b rd=%h busy=%b want all 0",
               mem_a, mem_dout, mem_wr, req_accept, resp_valid, resp_rdata, busy);
    end
    #2;
    rst_in = 1'b1;
    tick();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    mem[10'h100] = 8'h11;
    mem[10'h101] = 8'h22;
    mem[10'h102] = 8'h33;
    mem[10'h103] = 8'h44;
    mem[10'h010] = 8'h5A;
    mem[10'h011] = 8'h6B;
    mem[10'h012] = 8'h7C;
    mem_din        = 8'h00;
    rst_in         = 1'b0;
    rdy_in         = 1'b1;
    clear_in       = 1'b0;
    io_buffer_full = 1'b0;
    req_valid      = '0;
    req_write      = '0;
    req_size       = '0;
    req_addr       = '0;
    req_wdata      = '0;

    test_reset();
    test_word_read();
    test_half_write();
    test_round_robin();
    test_io_gating();
    test_clear();
    test_stall();
    test_async_reset();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
